// File: rtl/cache_plru_replacer_pkg.sv
// rtl/cache_plru_replacer_pkg.sv - shared sizing helpers and PLRU tree indexing for the replacer
package cache_plru_replacer_pkg;

  // Widest associativity the tree masks are built for (ASSOC_ORDER <= 3).
  localparam int MAX_WAYS = 8;

  // Tree nodes are heap-indexed: root is node 1, node n has children 2n
  // (left, lower-numbered ways) and 2n+1 (right). A tree bit of 0 means the
  // victim lies in the left subtree.
  localparam int TREE_ROOT = 1;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int WAYS_OF(input int order);
    return 1 << order;
  endfunction

  function automatic int TREE_BITS_OF(input int order);
    return (1 << order) - 1;
  endfunction

  // Ways covered by the left (right_half=0) or right (right_half=1) subtree
  // of a heap-indexed node in a tree with 2**order leaves.
  function automatic logic [MAX_WAYS-1:0] node_half_mask(input int order, input int node,
                                                         input bit right_half);
    int lvl;
    int pos;
    int span;
    int half;
    int base;
    logic [MAX_WAYS-1:0] m;
    lvl = 0;
    for (int k = node; k > TREE_ROOT; k = k / 2) lvl = lvl + 1;
    pos  = node - (1 << lvl);
    span = (1 << order) >> lvl;
    half = span / 2;
    base = pos * span + (right_half ? half : 0);
    m    = '0;
    for (int i = 0; i < MAX_WAYS; i++) m[i] = (i >= base) && (i < base + half);
    return m;
  endfunction

endpackage

// File: rtl/cache_plru_replacer_onehot_to_bin.sv
// rtl/cache_plru_replacer_onehot_to_bin.sv - one-hot to binary encoder with default for all-zero input
module OneHot_to_Bin
  import cache_plru_replacer_pkg::*;
#(
  parameter int ORDER   = 2,
  parameter int DEFAULT = 0
) (
  input  logic [WAYS_OF(ORDER)-1:0] i_onehot,
  output logic [max(ORDER,1)-1:0]   o_bin
);

  localparam int BIN_W = max(ORDER, 1);
  localparam int N     = WAYS_OF(ORDER);

  // OR together the indices of set bits; an empty input yields DEFAULT.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) o_bin = o_bin | BIN_W'(i);
    end
    if (i_onehot == '0) o_bin = BIN_W'(DEFAULT);
  end

endmodule

// File: rtl/cache_plru_replacer.sv
// rtl/cache_plru_replacer.sv - per-set tree pseudo-LRU victim selection with valid tracking
module cache_plru_replacer
  import cache_plru_replacer_pkg::*;
#(
  parameter int ASSOC_ORDER = 2,
  parameter int SET_ORDER   = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ACCESS_VALID,
  input  logic                          ACCESS_FILL,
  input  logic [SET_ORDER-1:0]          ACCESS_SET,
  input  logic [WAYS_OF(ASSOC_ORDER)-1:0] ACCESS_WAY,
  input  logic                          INVALIDATE_ALL,
  input  logic                          VICTIM_REQ,
  input  logic [SET_ORDER-1:0]          VICTIM_SET,
  output logic                          VICTIM_VALID,
  output logic [WAYS_OF(ASSOC_ORDER)-1:0] VICTIM_ONEHOT,
  output logic [max(ASSOC_ORDER,1)-1:0] VICTIM_BIN,
  output logic                          ACCESS_ERR
);

  localparam int WAYS      = WAYS_OF(ASSOC_ORDER);
  localparam int TREE_BITS = TREE_BITS_OF(ASSOC_ORDER);
  localparam int TREE_W    = max(TREE_BITS, 1);
  localparam int SETS      = 1 << SET_ORDER;

  // Bit k of a tree word holds heap node k+1.
  logic [WAYS-1:0]   r_valid [SETS];
  logic [TREE_W-1:0] r_tree  [SETS];
  logic              r_victim_valid;
  logic [WAYS-1:0]   r_victim_onehot;
  logic              r_access_err;

  logic              w_access_ok;
  logic              w_access_upd;
  logic [TREE_W-1:0] w_tree_cur;
  logic [TREE_W-1:0] w_tree_next;
  logic [TREE_W-1:0] w_hit_left;
  logic [TREE_W-1:0] w_hit_right;
  logic [WAYS-1:0]   w_vvalid;
  logic [TREE_W-1:0] w_vtree;
  logic [WAYS-1:0]   w_excl [TREE_W];
  logic [WAYS-1:0]   w_free;
  logic [WAYS-1:0]   w_walk;
  logic [WAYS-1:0]   w_victim;

  assign w_access_ok  = (ACCESS_WAY != '0) && ((ACCESS_WAY & (ACCESS_WAY - WAYS'(1))) == '0);
  assign w_access_upd = ACCESS_VALID && w_access_ok;
  assign w_tree_cur   = r_tree[ACCESS_SET];
  assign w_vvalid     = r_valid[VICTIM_SET];
  assign w_vtree      = r_tree[VICTIM_SET];

  // Per node: does the access land left/right of it, and which ways does the
  // lookup's tree bit rule out (bit 1 points right, so the left half is out).
  if (TREE_BITS == 0) begin : g_no_tree
    assign w_hit_left  = '0;
    assign w_hit_right = '0;
    assign w_excl[0]   = '0;
  end else begin : g_tree
    for (genvar n = 1; n <= TREE_BITS; n++) begin : g_node
      localparam logic [MAX_WAYS-1:0] L_MASK = node_half_mask(ASSOC_ORDER, n, 1'b0);
      localparam logic [MAX_WAYS-1:0] R_MASK = node_half_mask(ASSOC_ORDER, n, 1'b1);
      assign w_hit_left[n-1]  = |(ACCESS_WAY & L_MASK[WAYS-1:0]);
      assign w_hit_right[n-1] = |(ACCESS_WAY & R_MASK[WAYS-1:0]);
      assign w_excl[n-1]      = w_vtree[n-1] ? L_MASK[WAYS-1:0] : R_MASK[WAYS-1:0];
    end
  end

  // Nodes on the path point away from the touched way; off-path nodes keep their value.
  assign w_tree_next = (w_tree_cur | w_hit_left) & ~w_hit_right;

  // Victim: lowest invalid way if any, else the single leaf no node excludes.
  always_comb begin
    w_walk = '1;
    for (int i = 0; i < TREE_W; i++) w_walk = w_walk & ~w_excl[i];
    w_free   = ~w_vvalid & (w_vvalid + WAYS'(1));
    w_victim = (&w_vvalid) ? w_walk : w_free;
  end

  // Per-set valid and tree storage; flush wins over a same-cycle access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_tree[s]  <= '0;
      end
    end else if (INVALIDATE_ALL) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_tree[s]  <= '0;
      end
    end else if (w_access_upd) begin
      r_tree[ACCESS_SET] <= w_tree_next;
      if (ACCESS_FILL) r_valid[ACCESS_SET] <= r_valid[ACCESS_SET] | ACCESS_WAY;
    end
  end

  // Victim result register: pulse valid, hold the way until the next request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_victim_valid  <= 1'b0;
      r_victim_onehot <= '0;
    end else begin
      r_victim_valid <= VICTIM_REQ;
      if (VICTIM_REQ) r_victim_onehot <= w_victim;
    end
  end

  // Sticky flag for accesses whose way vector is not exactly one-hot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_access_err <= 1'b0;
    end else if (ACCESS_VALID && !w_access_ok) begin
      r_access_err <= 1'b1;
    end
  end

  OneHot_to_Bin #(
    .ORDER   (ASSOC_ORDER),
    .DEFAULT (0)
  ) u_onehot_to_bin (
    .i_onehot (r_victim_onehot),
    .o_bin    (VICTIM_BIN)
  );

  assign VICTIM_VALID  = r_victim_valid;
  assign VICTIM_ONEHOT = r_victim_onehot;
  assign ACCESS_ERR    = r_access_err;

endmodule

// File: tb/tb_cache_plru_replacer.sv
// tb/tb_cache_plru_replacer.sv - self-checking bench for the PLRU replacer against a tree-walk model
module tb_cache_plru_replacer;

  localparam int AO   = 2;
  localparam int SO   = 6;
  localparam int WAYS = 1 << AO;
  localparam int SETS = 1 << SO;

  logic            CLK;
  logic            RST;
  logic            ACCESS_VALID;
  logic            ACCESS_FILL;
  logic [SO-1:0]   ACCESS_SET;
  logic [WAYS-1:0] ACCESS_WAY;
  logic            INVALIDATE_ALL;
  logic            VICTIM_REQ;
  logic [SO-1:0]   VICTIM_SET;
  logic            VICTIM_VALID;
  logic [WAYS-1:0] VICTIM_ONEHOT;
  logic [AO-1:0]   VICTIM_BIN;
  logic            ACCESS_ERR;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  cache_plru_replacer #(.ASSOC_ORDER(AO), .SET_ORDER(SO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ACCESS_VALID   (ACCESS_VALID),
    .ACCESS_FILL    (ACCESS_FILL),
    .ACCESS_SET     (ACCESS_SET),
    .ACCESS_WAY     (ACCESS_WAY),
    .INVALIDATE_ALL (INVALIDATE_ALL),
    .VICTIM_REQ     (VICTIM_REQ),
    .VICTIM_SET     (VICTIM_SET),
    .VICTIM_VALID   (VICTIM_VALID),
    .VICTIM_ONEHOT  (VICTIM_ONEHOT),
    .VICTIM_BIN     (VICTIM_BIN),
    .ACCESS_ERR     (ACCESS_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: valid flags per way, tree nodes 1..WAYS-1 per set.
  bit              m_valid [SETS][WAYS];
  bit              m_tree  [SETS][WAYS];
  bit              m_err;
  logic            exp_valid;
  logic [WAYS-1:0] exp_onehot;
  logic [AO-1:0]   exp_bin;

  function automatic int model_victim(input int s);
    int node;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    node = 1;
    while (node < WAYS) node = 2 * node + int'(m_tree[s][node]);
    return node - WAYS;
  endfunction

  function automatic int way_index(input logic [WAYS-1:0] oh);
    for (int w = 0; w < WAYS; w++) if (oh[w]) return w;
    return 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          m_valid[s][w] <= 1'b0;
          m_tree[s][w]  <= 1'b0;
        end
      m_err      <= 1'b0;
      exp_valid  <= 1'b0;
      exp_onehot <= '0;
      exp_bin    <= '0;
    end else begin
      exp_valid <= VICTIM_REQ;
      if (VICTIM_REQ) begin
        exp_onehot <= WAYS'(1) << model_victim(int'(VICTIM_SET));
        exp_bin    <= AO'(model_victim(int'(VICTIM_SET)));
      end
      if (ACCESS_VALID && $countones(ACCESS_WAY) != 1) m_err <= 1'b1;
      if (INVALIDATE_ALL) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] <= 1'b0;
            m_tree[s][w]  <= 1'b0;
          end
      end else if (ACCESS_VALID && $countones(ACCESS_WAY) == 1) begin
        if (ACCESS_FILL) m_valid[ACCESS_SET][way_index(ACCESS_WAY)] <= 1'b1;
        for (int n = way_index(ACCESS_WAY) + WAYS; n > 1; n = n / 2)
          m_tree[ACCESS_SET][n/2] <= ((n % 2) == 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_valid",  32'(VICTIM_VALID),  32'(exp_valid));
      check("cmp_onehot", 32'(VICTIM_ONEHOT), 32'(exp_onehot));
      check("cmp_bin",    32'(VICTIM_BIN),    32'(exp_bin));
      check("cmp_err",    32'(ACCESS_ERR),    32'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    ACCESS_VALID   = 1'b0;
    ACCESS_FILL    = 1'b0;
    ACCESS_SET     = '0;
    ACCESS_WAY     = '0;
    INVALIDATE_ALL = 1'b0;
    VICTIM_REQ     = 1'b0;
    VICTIM_SET     = '0;
  endtask

  task automatic do_access(input int s, input logic [WAYS-1:0] way, input bit fill);
    ACCESS_VALID = 1'b1;
    ACCESS_FILL  = fill;
    ACCESS_SET   = SO'(s);
    ACCESS_WAY   = way;
    step();
    idle();
  endtask

  task automatic expect_victim(input string name, input logic [WAYS-1:0] oh, input int bin);
    check({name, "_valid"},  32'(VICTIM_VALID),  32'd1);
    check({name, "_onehot"}, 32'(VICTIM_ONEHOT), 32'(oh));
    check({name, "_bin"},    32'(VICTIM_BIN),    32'(bin));
  endtask

  task automatic do_req(input string name, input int s, input logic [WAYS-1:0] oh, input int bin);
    VICTIM_REQ = 1'b1;
    VICTIM_SET = SO'(s);
    step();
    idle();
    expect_victim(name, oh, bin);
  endtask

  initial begin
    RST = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    step();
    check("rst_valid",  32'(VICTIM_VALID),  32'd0);
    check("rst_onehot", 32'(VICTIM_ONEHOT), 32'd0);
    check("rst_bin",    32'(VICTIM_BIN),    32'd0);
    check("rst_err",    32'(ACCESS_ERR),    32'd0);
    RST = 1'b0;
    step();

    do_req("empty_set5", 5, 4'b0001, 0);
    check("err_clear", 32'(ACCESS_ERR), 32'd0);
    step();
    check("valid_drops", 32'(VICTIM_VALID), 32'd0);

    // Fill every way of set 5 in order: tree ends all-zero, walk lands on way 0.
    for (int w = 0; w < WAYS; w++) do_access(5, WAYS'(1) << w, 1'b1);
    do_req("full_set5", 5, 4'b0001, 0);

    // Hit way 1: root -> right, node 3 still 0 -> way 2.
    do_access(5, 4'b0010, 1'b0);
    do_req("hit1_set5", 5, 4'b0100, 2);
    do_req("set6_untouched", 6, 4'b0001, 0);

    // Same-cycle hit on way 3 and lookup: result uses the pre-hit tree.
    ACCESS_VALID = 1'b1; ACCESS_SET = 6'd5; ACCESS_WAY = 4'b1000;
    VICTIM_REQ = 1'b1; VICTIM_SET = 6'd5;
    step();
    idle();
    expect_victim("rbw_pre", 4'b0100, 2);
    do_req("rbw_post", 5, 4'b0001, 0);

    // Multi-hot access: sticky error, no state change.
    do_access(5, 4'b0110, 1'b0);
    check("err_set", 32'(ACCESS_ERR), 32'd1);
    do_req("err_nochange", 5, 4'b0001, 0);
    do_access(5, 4'b0000, 1'b1);
    do_req("zero_way_nochange", 5, 4'b0001, 0);

    // Back-to-back lookups on different sets.
    do_access(6, 4'b0001, 1'b1);
    VICTIM_REQ = 1'b1; VICTIM_SET = 6'd5;
    step();
    expect_victim("b2b_first", 4'b0001, 0);
    VICTIM_SET = 6'd6;
    step();
    idle();
    expect_victim("b2b_second", 4'b0010, 1);

    // Flush with a simultaneous lookup (sees old state) and a dropped fill.
    do_access(5, 4'b0001, 1'b0);
    do_req("pre_flush", 5, 4'b0100, 2);
    INVALIDATE_ALL = 1'b1;
    ACCESS_VALID = 1'b1; ACCESS_FILL = 1'b1; ACCESS_SET = 6'd5; ACCESS_WAY = 4'b0001;
    VICTIM_REQ = 1'b1; VICTIM_SET = 6'd5;
    step();
    idle();
    expect_victim("flush_same_cycle", 4'b0100, 2);
    do_req("post_flush", 5, 4'b0001, 0);
    do_req("post_flush_set6", 6, 4'b0001, 0);
    check("err_survives_flush", 32'(ACCESS_ERR), 32'd1);

    // Reset right after a lookup result: everything drops immediately.
    VICTIM_REQ = 1'b1; VICTIM_SET = 6'd5;
    step();
    idle();
    #1 RST = 1'b1;
    #1;
    check("midrst_valid",  32'(VICTIM_VALID),  32'd0);
    check("midrst_onehot", 32'(VICTIM_ONEHOT), 32'd0);
    check("midrst_bin",    32'(VICTIM_BIN),    32'd0);
    check("midrst_err",    32'(ACCESS_ERR),    32'd0);
    step();
    RST = 1'b0;
    step();
    do_req("after_rst", 5, 4'b0001, 0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
